// File: rtl/aes_block_packer_if.sv
// ---------------------------------------------------------------------------
// aes_block_packer_if
// Byte-stream / block handshake bundle between the UART receiver, the block
// packer and the AES core.
//   rx_valid    : one-cycle strobe, rx_data holds a received byte
//   rx_data     : received byte
//   block_ready : AES stage accepts the presented block this cycle
//   block_out   : assembled 128-bit block, first byte in [127:120]
//   block_valid : block_out holds a complete block
//   byte_cnt    : bytes held in the current block, 0..16
//   overrun     : one-cycle pulse, a byte was dropped while a block was full
//   timeout     : one-cycle pulse, a partial block was discarded
// Modports: slave = packer side, master = byte source / block sink side.
// ---------------------------------------------------------------------------
interface aes_block_packer_if;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         block_ready;
  logic [127:0] block_out;
  logic         block_valid;
  logic [4:0]   byte_cnt;
  logic         overrun;
  logic         timeout;

  modport slave (
    input  rx_valid, rx_data, block_ready,
    output block_out, block_valid, byte_cnt, overrun, timeout
  );

  modport master (
    output rx_valid, rx_data, block_ready,
    input  block_out, block_valid, byte_cnt, overrun, timeout
  );
endinterface

// File: rtl/aes_block_packer.sv
// ---------------------------------------------------------------------------
// aes_block_packer
// Packs the UART byte stream into 128-bit blocks for the AES core. Bytes are
// shifted in at the low end so the first byte of a block ends in [127:120].
// A full block is held until the AES stage takes it; bytes arriving while
// the block waits are dropped and flagged on overrun.
//
// Optional feature macro: AES_PACKER_TIMEOUT_EN
//   defined   : a partial block idle for TIMEOUT_CYCLES cycles is discarded
//               and timeout pulses once.
//   undefined : no timer, timeout is tied to 0.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : aes_block_packer_if.slave (see interface file for signal list)
// Parameter:
//   TIMEOUT_CYCLES : idle cycles tolerated inside a partial block (>= 2)
// ---------------------------------------------------------------------------
module aes_block_packer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_block_packer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [127:0] block;
  logic [127:0] next_block;
  logic [4:0]   cnt;
  logic [4:0]   next_cnt;
  logic         valid;
  logic         overrun_q;
  logic         next_overrun;
  logic [127:0] shifted;

  assign shifted = {block[119:0], bus.rx_data};

`ifdef AES_PACKER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  logic [TW-1:0] timer;
  logic [TW-1:0] next_timer;
  logic          timeout_q;
  logic          next_timeout;
`endif

  // Next-state, next-data and pulse decode for the packer FSM.
  always_comb begin
    next_state   = state;
    next_block   = block;
    next_cnt     = cnt;
    next_overrun = 1'b0;
`ifdef AES_PACKER_TIMEOUT_EN
    next_timer   = {TW{1'b0}};
    next_timeout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          next_block = shifted;
          next_cnt   = 5'd1;
          next_state = FILL;
        end else begin
          next_state = IDLE;
        end
      end

      FILL: begin
        if (bus.rx_valid) begin
          next_block = shifted;
          next_cnt   = cnt + 5'd1;
          if (cnt == 5'd15) begin
            next_state = FULL;
          end else begin
            next_state = FILL;
          end
        end else begin
`ifdef AES_PACKER_TIMEOUT_EN
          // Expiry only when no byte arrives this cycle; a late byte wins.
          if (timer == TIMER_LAST) begin
            next_state   = IDLE;
            next_cnt     = 5'd0;
            next_block   = 128'd0;
            next_timeout = 1'b1;
          end else if (timer != TIMER_MAX) begin
            next_timer = timer + {{(TW-1){1'b0}}, 1'b1};
          end else begin
            next_timer = timer;
          end
`else
          next_state = FILL;
`endif
        end
      end

      FULL: begin
        if (bus.block_ready) begin
          // Handshake completes; a byte in the same cycle starts the next block.
          if (bus.rx_valid) begin
            next_block = shifted;
            next_cnt   = 5'd1;
            next_state = FILL;
          end else begin
            next_cnt   = 5'd0;
            next_state = IDLE;
          end
        end else if (bus.rx_valid) begin
          next_overrun = 1'b1;
        end else begin
          next_state = FULL;
        end
      end

      default: begin
        next_state = IDLE;
        next_cnt   = 5'd0;
        next_block = 128'd0;
      end
    endcase
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      block     <= 128'd0;
      cnt       <= 5'd0;
      valid     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= next_state;
      block     <= next_block;
      cnt       <= next_cnt;
      valid     <= (next_state == FULL);
      overrun_q <= next_overrun;
    end
  end

`ifdef AES_PACKER_TIMEOUT_EN
  // Inter-byte idle timer and its discard pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= {TW{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      timer     <= next_timer;
      timeout_q <= next_timeout;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.block_out   = block;
  assign bus.block_valid = valid;
  assign bus.byte_cnt    = cnt;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_block_packer
// Directed scenarios followed by randomized traffic. The reference keeps the
// accepted byte history and block occupancy as plain counters/queues.
// ---------------------------------------------------------------------------
module tb_aes_block_packer;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  aes_block_packer_if bus ();

  aes_block_packer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: bytes in current block, last 16 accepted bytes since a clear,
  // idle cycles inside a partial block, expected pulses.
  int         n = 0;
  logic [7:0] hist[$];
  int         idle = 0;
  logic       exp_ov = 1'b0;
  logic       exp_to = 1'b0;

  function automatic logic [127:0] pack_hist();
    logic [127:0] r = 128'd0;
    foreach (hist[i]) r = {r[119:0], hist[i]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("byte_cnt", 128'(bus.byte_cnt), 128'(n));
    chk("block_valid", 128'(bus.block_valid), 128'(n == 16));
    chk("block_out", bus.block_out, pack_hist());
    chk("overrun", 128'(bus.overrun), 128'(exp_ov));
    chk("timeout", 128'(bus.timeout), 128'(exp_to));
  endtask

  task automatic accept(input logic [7:0] d);
    hist.push_back(d);
    if (hist.size() > 16) void'(hist.pop_front());
    n++;
    idle = 0;
  endtask

  task automatic model(input logic v, input logic [7:0] d, input logic rdy);
    exp_ov = 1'b0;
    exp_to = 1'b0;
    if (n == 16) begin
      idle = 0;
      if (rdy) begin
        n = 0;
        if (v) accept(d);
      end else if (v) begin
        exp_ov = 1'b1;
      end
    end else if (v) begin
      accept(d);
    end else if (n != 0) begin
`ifdef AES_PACKER_TIMEOUT_EN
      idle++;
      if (idle == TO) begin
        n = 0;
        hist.delete();
        idle = 0;
        exp_to = 1'b1;
      end
`endif
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rdy);
    bus.rx_valid    = v;
    bus.rx_data     = d;
    bus.block_ready = rdy;
    @(posedge clk);
    model(v, d, rdy);
    #1;
    check_all();
    bus.rx_valid    = 1'b0;
    bus.block_ready = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    n = 0;
    idle = 0;
    hist.delete();
    exp_ov = 1'b0;
    exp_to = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    int           p;
    blk_a = 128'h000102030405060708090a0b0c0d0e0f;
    blk_b = 128'h101112131415161718191a1b1c1d1e1f;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.block_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Basic fill 00..0F
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_block", bus.block_out, blk_a);
    chk("fill_cnt", 128'(bus.byte_cnt), 128'd16);

    // Overrun, then take the block
    step(1'b1, 8'hAA, 1'b0);
    chk("ovr_pulse", 128'(bus.overrun), 128'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovr_block", bus.block_out, blk_a);
    step(1'b0, 8'h00, 1'b1);
    chk("taken_valid", 128'(bus.block_valid), 128'd0);

    // Simultaneous handshake and byte
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    chk("hs_low", 128'(bus.block_out[7:0]), 128'h5A);
    chk("hs_cnt", 128'(bus.byte_cnt), 128'd1);

    // Stray ready during FILL and IDLE
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h10 + 8'(i)), 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset mid-fill
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0);
    async_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + 8'(i)), 1'b0);
    chk("post_rst_block", bus.block_out, blk_b);
    step(1'b0, 8'h00, 1'b1);

`ifdef AES_PACKER_TIMEOUT_EN
    // Timeout: 5 bytes then idle; byte on the expiry cycle is kept
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < TO + 2; i++) step(1'b0, 8'h00, 1'b0);
    chk("to_cnt", 128'(bus.byte_cnt), 128'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    chk("late_byte_cnt", 128'(bus.byte_cnt), 128'd4);
    async_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + 8'(i)), 1'b0);
    chk("to_block", bus.block_out, blk_b);
    step(1'b0, 8'h00, 1'b1);
`endif

    // Randomized traffic with phases of dense, medium and sparse bytes
    p = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       p = 1;
          1:       p = 3;
          default: p = 16;
        endcase
      end
      step(($urandom_range(1, p) == 1), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
